struct_demux16: RTL and testbench

//  16-channel registered demultiplexer/loader. Accepts one CHANSIZE-bit word per

---
 rtl/demux16_pkg.sv | 29 ++
 rtl/struct_demux16_dec4to16.sv | 20 ++
 rtl/struct_demux16.sv | 95 +++++++++
 tb/tb_struct_demux16.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/demux16_pkg.sv
// Shared constants and helpers for the 16-channel demultiplexer/loader.
//   NCHAN     : number of channels
//   ADDRW     : width of the binary channel address
//   OCCW      : width of the occupancy count (0..16)
//   onehot16  : binary address to one-hot vector
//   popcount16: number of set bits in a 16-bit vector
package demux16_pkg;

    localparam int NCHAN = 16;
    localparam int ADDRW = 4;
    localparam int OCCW  = 5;

    function automatic logic [NCHAN-1:0] onehot16(input logic [ADDRW-1:0] addr);
        logic [NCHAN-1:0] oh;
        oh = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

    function automatic logic [OCCW-1:0] popcount16(input logic [NCHAN-1:0] v);
        logic [OCCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cnt = cnt + OCCW'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/struct_demux16_dec4to16.sv
// Combinational binary-to-one-hot decoder.
//   addr_i   : 4-bit binary channel address
//   en_i     : when low, the output is all zeros
//   onehot_o : one-hot decode of addr_i, gated by en_i (used as write enables)
module dec4to16
    import demux16_pkg::*;
(
    input  logic [ADDRW-1:0] addr_i,
    input  logic             en_i,
    output logic [NCHAN-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = onehot16(addr_i);
        end
    end

endmodule

// File: rtl/struct_demux16.sv
// 16-channel registered demultiplexer/loader.
// Accepts one word per cycle under valid/ready, stores it in the addressed
// channel's holding register and marks that channel loaded until consumed.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : producer offers in_data/in_addr
//   in_ready  : target channel is free and no flush/reset is in progress
//   in_data   : word to load
//   in_addr   : binary target channel
//   consume   : per-channel acknowledge from downstream, clears loaded[i]
//   clear     : flush all loaded flags and select (channel contents kept)
//   channels  : holding registers, one per channel
//   select    : one-cycle one-hot pulse of the channel written last edge
//   loaded    : channel holds an unconsumed word
//   occupancy : number of loaded channels
//   full      : all 16 channels loaded
module struct_demux16
    import demux16_pkg::*;
#(
    parameter int CHANSIZE = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANSIZE-1:0]             in_data,
    input  logic [ADDRW-1:0]                in_addr,
    input  logic [NCHAN-1:0]                consume,
    input  logic                            clear,
    output logic [NCHAN-1:0][CHANSIZE-1:0]  channels,
    output logic [NCHAN-1:0]                select,
    output logic [NCHAN-1:0]                loaded,
    output logic [OCCW-1:0]                 occupancy,
    output logic                            full
);

    logic [NCHAN-1:0][CHANSIZE-1:0] channels_q;
    logic [NCHAN-1:0]               select_q, select_d;
    logic [NCHAN-1:0]               loaded_q, loaded_d;
    logic [OCCW-1:0]                occ_q, occ_d;
    logic                           full_q, full_d;

    logic                           accept;
    logic [NCHAN-1:0]               we;

    // A loaded channel is never overwritten; full implies every channel is
    // loaded, so this also blocks all writes when full.
    assign in_ready = ~loaded_q[in_addr] & ~clear & ~rst;
    assign accept   = in_valid & in_ready;

    dec4to16 u_dec (
        .addr_i   (in_addr),
        .en_i     (accept),
        .onehot_o (we)
    );

    always_comb begin
        select_d = we;
        loaded_d = (loaded_q & ~consume) | we;
        // Only consumes of actually loaded channels reduce the count.
        occ_d    = occ_q + OCCW'(accept) - popcount16(consume & loaded_q);
        if (clear) begin
            select_d = '0;
            loaded_d = '0;
            occ_d    = '0;
        end
        full_d = (occ_d == OCCW'(NCHAN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            channels_q <= '0;
            select_q   <= '0;
            loaded_q   <= '0;
            occ_q      <= '0;
            full_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (we[i]) begin
                    channels_q[i] <= in_data;
                end
            end
            select_q <= select_d;
            loaded_q <= loaded_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
        end
    end

    assign channels  = channels_q;
    assign select    = select_q;
    assign loaded    = loaded_q;
    assign occupancy = occ_q;
    assign full      = full_q;

endmodule

// File: tb/tb_struct_demux16.sv
module tb_struct_demux16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_data;
    logic [3:0]        in_addr;
    logic [15:0]       consume;
    logic              clear;
    logic [15:0][1:0]  channels;
    logic [15:0]       select;
    logic [15:0]       loaded;
    logic [4:0]        occupancy;
    logic              full;

    int errors = 0;
    int checks = 0;

    struct_demux16 #(.CHANSIZE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .consume   (consume),
        .clear     (clear),
        .channels  (channels),
        .select    (select),
        .loaded    (loaded),
        .occupancy (occupancy),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_addr = 4'd5; in_data = 2'b11;
        consume = '0; clear = 1'b0;
        tick(); tick();
        checks++; if (loaded !== 16'h0000) begin errors++; $display("FAIL reset_loaded got=%h exp=%h", loaded, 16'h0000); end
        checks++; if (select !== 16'h0000) begin errors++; $display("FAIL reset_select got=%h exp=%h", select, 16'h0000); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (channels !== 32'h0) begin errors++; $display("FAIL reset_channels got=%h exp=0", channels); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (loaded !== 16'h0000) begin errors++; $display("FAIL reset_nowrite got=%h exp=0", loaded); end
    endtask

    task automatic test_single_load();
        in_valid = 1'b1; in_addr = 4'd5; in_data = 2'b10;
        tick();
        in_valid = 1'b0;
        checks++; if (channels[5] !== 2'b10) begin errors++; $display("FAIL single_data got=%b exp=10", channels[5]); end
        checks++; if (loaded !== 16'h0020) begin errors++; $display("FAIL single_loaded got=%h exp=0020", loaded); end
        checks++; if (select !== 16'h0020) begin errors++; $display("FAIL single_select got=%h exp=0020", select); end
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
        tick();
        checks++; if (select !== 16'h0000) begin errors++; $display("FAIL single_select_pulse got=%h exp=0", select); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_addr = 4'd3; in_data = 2'b11;
        tick();
        in_data = 2'b01;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
        tick();
        checks++; if (channels[3] !== 2'b11) begin errors++; $display("FAIL bp_hold got=%b exp=11", channels[3]); end
        consume = 16'h0008;
        tick();
        consume = '0;
        checks++; if (channels[3] !== 2'b11) begin errors++; $display("FAIL bp_consume_keep got=%b exp=11", channels[3]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (channels[3] !== 2'b01) begin errors++; $display("FAIL bp_write_lands got=%b exp=01", channels[3]); end
        checks++; if (loaded !== 16'h0028) begin errors++; $display("FAIL bp_loaded got=%h exp=0028", loaded); end
        checks++; if (occupancy !== 5'd2) begin errors++; $display("FAIL bp_occ got=%0d exp=2", occupancy); end
        consume = 16'hFFFF;
        tick();
        consume = '0;
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_addr = 4'(i); in_data = 2'(i);
            tick();
            checks++; if (occupancy !== 5'(i + 1)) begin errors++; $display("FAIL fill_occ_%0d got=%0d exp=%0d", i, occupancy, i + 1); end
        end
        in_addr = 4'd9;
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (loaded !== 16'hFFFF) begin errors++; $display("FAIL fill_loaded got=%h exp=FFFF", loaded); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", in_ready); end
        checks++; if (channels !== 32'hE4E4E4E4) begin errors++; $display("FAIL fill_channels got=%h exp=E4E4E4E4", channels); end
        in_valid = 1'b0;
        consume = 16'hFFFF;
        tick();
        consume = '0;
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL fill_drain_occ got=%0d exp=0", occupancy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_drain_full got=%b exp=0", full); end
        checks++; if (channels[9] !== 2'b01) begin errors++; $display("FAIL fill_keep got=%b exp=01", channels[9]); end
    endtask

    task automatic test_simultaneous();
        in_valid = 1'b1; in_addr = 4'd2; in_data = 2'b01;
        tick();
        in_addr = 4'd7; in_data = 2'b11; consume = 16'h0004;
        tick();
        in_valid = 1'b0; consume = '0;
        checks++; if (loaded !== 16'h0080) begin errors++; $display("FAIL sim_loaded got=%h exp=0080", loaded); end
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL sim_occ got=%0d exp=1", occupancy); end
        // consume of an unloaded channel must not change the count
        consume = 16'h0100;
        tick();
        consume = '0;
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL sim_consume_unloaded got=%0d exp=1", occupancy); end
        in_valid = 1'b1; in_addr = 4'd10; in_data = 2'b01; clear = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0; clear = 1'b0;
        checks++; if (loaded !== 16'h0000) begin errors++; $display("FAIL clr_loaded got=%h exp=0", loaded); end
        checks++; if (select !== 16'h0000) begin errors++; $display("FAIL clr_select got=%h exp=0", select); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL clr_occ got=%0d exp=0", occupancy); end
        checks++; if (channels[10] !== 2'b10) begin errors++; $display("FAIL clr_nowrite got=%b exp=10", channels[10]); end
        checks++; if (channels[7] !== 2'b11) begin errors++; $display("FAIL clr_keep got=%b exp=11", channels[7]); end
    endtask

    task automatic test_midreset();
        logic [3:0] addrs [4] = '{4'd1, 4'd4, 4'd8, 4'd12};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = addrs[i]; in_data = 2'b11;
            tick();
        end
        checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL mr_occ_pre got=%0d exp=4", occupancy); end
        rst = 1'b1; in_addr = 4'd0; consume = 16'h0002;
        tick();
        rst = 1'b0; in_valid = 1'b0; consume = '0;
        checks++; if (loaded !== 16'h0000) begin errors++; $display("FAIL mr_loaded got=%h exp=0", loaded); end
        checks++; if (select !== 16'h0000) begin errors++; $display("FAIL mr_select got=%h exp=0", select); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mr_occ got=%0d exp=0", occupancy); end
        checks++; if (channels !== 32'h0) begin errors++; $display("FAIL mr_channels got=%h exp=0", channels); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL mr_full got=%b exp=0", full); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0;
        consume = '0; clear = 1'b0;
        test_reset();
        test_single_load();
        test_backpressure();
        test_fill();
        test_simultaneous();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
